// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the centisecond stopwatch and its 7-segment display.
// Holds the FSM state encoding, active-low segment codes and the cascaded BCD increment.
package stopwatch_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Four cascaded decimal digits; 9999 rolls over to 0000.
  function automatic logic [4*BCD_W-1:0] bcd_inc(input logic [4*BCD_W-1:0] v);
    logic [4*BCD_W-1:0] r;
    logic               c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*BCD_W +: BCD_W] == 4'd9) begin
          r[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Zero latency; non-decimal codes show a blank digit.
module seg7_decoder
  import stopwatch_display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Centisecond stopwatch with start/pause and clear keys, scanning a 4-digit common-anode display.
// Presses act one cycle after the 100 Hz tick that samples them; an/seg refresh on each 1 kHz tick.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DP_DIGIT    = 2
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        clk_100hz,
  input  logic        clk_1khz,
  input  logic        key_start,
  input  logic        key_clear,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        running,
  output logic [15:0] bcd
);

  logic [SYNC_STAGES-1:0] r_sync_100, r_sync_1k, r_sync_ks, r_sync_kc;
  logic                   r_prev_100, r_prev_1k;
  logic                   r_ks_samp, r_kc_samp;
  logic                   r_press_start, r_press_clear;
  sw_state_t              r_state, w_state_nxt;
  logic                   r_running;
  logic [15:0]            r_bcd;
  logic [1:0]             r_idx;
  logic [3:0]             r_an;
  logic [7:0]             r_seg;
  logic                   w_tick100, w_tick1k;
  logic [BCD_W-1:0]       w_digit;
  logic [6:0]             w_seg7;

  assign w_tick100 = r_sync_100[SYNC_STAGES-1] & ~r_prev_100;
  assign w_tick1k  = r_sync_1k[SYNC_STAGES-1]  & ~r_prev_1k;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_sync_100 <= '0;
      r_sync_1k  <= '0;
      r_sync_ks  <= '0;
      r_sync_kc  <= '0;
      r_prev_100 <= 1'b0;
      r_prev_1k  <= 1'b0;
    end else begin
      r_sync_100 <= {r_sync_100[SYNC_STAGES-2:0], clk_100hz};
      r_sync_1k  <= {r_sync_1k[SYNC_STAGES-2:0],  clk_1khz};
      r_sync_ks  <= {r_sync_ks[SYNC_STAGES-2:0],  key_start};
      r_sync_kc  <= {r_sync_kc[SYNC_STAGES-2:0],  key_clear};
      r_prev_100 <= r_sync_100[SYNC_STAGES-1];
      r_prev_1k  <= r_sync_1k[SYNC_STAGES-1];
    end
  end

  // Sampling keys only at 100 Hz rejects bounce shorter than 10 ms.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_ks_samp     <= 1'b0;
      r_kc_samp     <= 1'b0;
      r_press_start <= 1'b0;
      r_press_clear <= 1'b0;
    end else if (w_tick100) begin
      r_ks_samp     <= r_sync_ks[SYNC_STAGES-1];
      r_kc_samp     <= r_sync_kc[SYNC_STAGES-1];
      r_press_start <= r_sync_ks[SYNC_STAGES-1] & ~r_ks_samp;
      r_press_clear <= r_sync_kc[SYNC_STAGES-1] & ~r_kc_samp;
    end else begin
      r_press_start <= 1'b0;
      r_press_clear <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_press_clear) begin
      w_state_nxt = IDLE;
    end else if (r_press_start) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      if (r_press_clear) begin
        r_bcd <= '0;
      end else if (w_tick100 && r_state == RUN) begin
        r_bcd <= bcd_inc(r_bcd);
      end
    end
  end

  always_comb begin
    w_digit = r_bcd[3:0];
    case (r_idx)
      2'd0:    w_digit = r_bcd[3:0];
      2'd1:    w_digit = r_bcd[7:4];
      2'd2:    w_digit = r_bcd[11:8];
      default: w_digit = r_bcd[15:12];
    endcase
  end

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg7)
  );

  // an/seg latch the digit at the current index while the index advances.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else if (w_tick1k) begin
      r_idx <= r_idx + 2'd1;
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= {(r_idx != 2'(DP_DIGIT)), w_seg7};
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign running = r_running;
  assign bcd     = r_bcd;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: a vector table of key/tick steps with expected count
// and run flag, plus hand-written reset, display-scan and mid-run reset sequences.
module tb_stopwatch_display;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic        clk_100hz = 1'b0;
  logic        clk_1khz = 1'b0;
  logic        key_start = 1'b0;
  logic        key_clear = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        running;
  logic [15:0] bcd;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_display #(.SYNC_STAGES(2), .DP_DIGIT(2)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clk_100hz (clk_100hz),
    .clk_1khz  (clk_1khz),
    .key_start (key_start),
    .key_clear (key_clear),
    .seg       (seg),
    .an        (an),
    .running   (running),
    .bcd       (bcd)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    string       name;
    logic        ks;
    logic        kc;
    int          n100;
    logic [15:0] exp_bcd;
    logic        exp_run;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic settle();
    repeat (5) @(negedge clk_50mhz);
  endtask

  task automatic tick100(input int n);
    repeat (n) begin
      clk_100hz = 1'b1;
      @(negedge clk_50mhz);
      clk_100hz = 1'b0;
      @(negedge clk_50mhz);
    end
    settle();
  endtask

  task automatic tick1k();
    clk_1khz = 1'b1;
    @(negedge clk_50mhz);
    clk_1khz = 1'b0;
    settle();
  endtask

  task automatic chk_disp(input string nm, input logic [3:0] e_an, input logic [7:0] e_seg);
    chk({nm, ".an"},  {12'h0, an},  {12'h0, e_an});
    chk({nm, ".seg"}, {8'h0, seg},  {8'h0, e_seg});
  endtask

  initial begin
    vt[0]  = '{"start_held",   1'b1, 1'b0, 2,    16'h0001, 1'b1};
    vt[1]  = '{"count25",      1'b0, 1'b0, 24,   16'h0025, 1'b1};
    vt[2]  = '{"count136",     1'b0, 1'b0, 111,  16'h0136, 1'b1};
    vt[3]  = '{"pause",        1'b1, 1'b0, 1,    16'h0137, 1'b0};
    vt[4]  = '{"paused_hold",  1'b0, 1'b0, 10,   16'h0137, 1'b0};
    vt[5]  = '{"resume",       1'b1, 1'b0, 1,    16'h0137, 1'b1};
    vt[6]  = '{"resume_cnt",   1'b0, 1'b0, 1,    16'h0138, 1'b1};
    vt[7]  = '{"count512",     1'b0, 1'b0, 374,  16'h0512, 1'b1};
    vt[8]  = '{"clear_prio",   1'b1, 1'b1, 1,    16'h0000, 1'b0};
    vt[9]  = '{"idle_nocnt",   1'b0, 1'b0, 1,    16'h0000, 1'b0};
    vt[10] = '{"restart",      1'b1, 1'b0, 1,    16'h0000, 1'b1};
    vt[11] = '{"count9999",    1'b0, 1'b0, 9999, 16'h9999, 1'b1};
    vt[12] = '{"wrap",         1'b0, 1'b0, 1,    16'h0000, 1'b1};
    vt[13] = '{"count1233",    1'b0, 1'b0, 1233, 16'h1233, 1'b1};
    vt[14] = '{"pause1234",    1'b1, 1'b0, 1,    16'h1234, 1'b0};

    // Reset held three cycles with bouncing keys.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      key_start = ~key_start;
      key_clear = (i == 1);
    end
    key_start = 1'b0;
    key_clear = 1'b0;
    @(negedge clk_50mhz);
    chk("rst.bcd", bcd, 16'h0000);
    chk("rst.running", {15'h0, running}, 16'h0000);
    chk_disp("rst", 4'b1111, 8'hFF);
    rst = 1'b0;
    settle();
    chk_disp("pre_scan", 4'b1111, 8'hFF);

    tick1k();
    chk_disp("scan0_zero", 4'b1110, 8'hC0);
    tick1k();
    chk_disp("scan1_zero", 4'b1101, 8'hC0);
    tick1k();
    chk_disp("scan2_zero", 4'b1011, 8'h40);
    tick1k();
    chk_disp("scan3_zero", 4'b0111, 8'hC0);

    for (int i = 0; i < 15; i++) begin
      key_start = vt[i].ks;
      key_clear = vt[i].kc;
      tick100(vt[i].n100);
      key_start = 1'b0;
      key_clear = 1'b0;
      chk({vt[i].name, ".bcd"}, bcd, vt[i].exp_bcd);
      chk({vt[i].name, ".running"}, {15'h0, running}, {15'h0, vt[i].exp_run});
    end

    // Display scan of 12.34 with the decimal point on digit 2.
    tick1k();
    chk_disp("scan_d0", 4'b1110, 8'h99);
    tick1k();
    chk_disp("scan_d1", 4'b1101, 8'hB0);
    tick1k();
    chk_disp("scan_d2", 4'b1011, 8'h24);
    chk("dp_d2", {15'h0, seg[7]}, 16'h0000);
    tick1k();
    chk_disp("scan_d3", 4'b0111, 8'hF9);
    tick100(3);
    chk("paused_scan.bcd", bcd, 16'h1234);

    // Resume, then reset in the middle of a run.
    key_start = 1'b1;
    tick100(1);
    key_start = 1'b0;
    tick100(2);
    chk("run_again.bcd", bcd, 16'h1236);
    chk("run_again.running", {15'h0, running}, 16'h0001);
    key_start = 1'b1;
    clk_100hz = 1'b1;
    rst = 1'b1;
    @(negedge clk_50mhz);
    chk("midrst.bcd", bcd, 16'h0000);
    chk("midrst.running", {15'h0, running}, 16'h0000);
    chk_disp("midrst", 4'b1111, 8'hFF);
    rst = 1'b0;
    clk_100hz = 1'b0;
    key_start = 1'b0;
    tick100(3);
    chk("after_rst.bcd", bcd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
